// File: rtl/wb_shared_bus_if.sv
// Wishbone shared-bus bundle: all master-side and slave-side signals of the interconnect.
// Signal suffixes are from the interconnect's point of view.
interface wb_shared_bus_if #(
    parameter int unsigned NM = 3,
    parameter int unsigned NS = 3,
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    localparam int unsigned SW = DW / 8;

    logic [NM-1:0]    m_cyc_i;
    logic [NM-1:0]    m_stb_i;
    logic [NM-1:0]    m_we_i;
    logic [NM*SW-1:0] m_sel_i;
    logic [NM*AW-1:0] m_adr_i;
    logic [NM*DW-1:0] m_dat_i;
    logic [NM*DW-1:0] m_dat_o;
    logic [NM-1:0]    m_ack_o;
    logic [NM-1:0]    m_err_o;
    logic [NM-1:0]    m_rty_o;

    logic [NS-1:0]    s_cyc_o;
    logic [NS-1:0]    s_stb_o;
    logic             s_we_o;
    logic [SW-1:0]    s_sel_o;
    logic [AW-1:0]    s_adr_o;
    logic [DW-1:0]    s_dat_o;
    logic [NS*DW-1:0] s_dat_i;
    logic [NS-1:0]    s_ack_i;
    logic [NS-1:0]    s_err_i;
    logic [NS-1:0]    s_rty_i;

    // Interconnect side.
    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
        output m_dat_o, m_ack_o, m_err_o, m_rty_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        input  s_dat_i, s_ack_i, s_err_i, s_rty_i
    );

    // Environment side: the masters and slaves attached to the fabric.
    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
        input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        output s_dat_i, s_ack_i, s_err_i, s_rty_i
    );
endinterface

// File: rtl/wb_shared_bus.sv
// Wishbone B3 shared-bus interconnect: round-robin arbitration, base/mask decode,
// error response for unmapped addresses and a watchdog that terminates hung cycles.
module wb_shared_bus #(
    parameter int unsigned       NM       = 3,
    parameter int unsigned       NS       = 3,
    parameter int unsigned       AW       = 32,
    parameter int unsigned       DW       = 32,
    parameter logic [NS*AW-1:0] SLV_BASE = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NS*AW-1:0] SLV_MASK = {3{32'hF000_0000}},
    parameter int unsigned       TIMEOUT  = 255
) (
    input logic            clk_i,
    input logic            rst_i,
    wb_shared_bus_if.slave bus
);
    localparam int unsigned SW     = DW / 8;
    localparam int unsigned IW     = (NM > 1) ? $clog2(NM) : 1;
    localparam int unsigned HW     = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [15:0] WdLast = 16'(TIMEOUT - 1);

    logic          gnt_vld_q, gnt_vld_d;
    logic [IW-1:0] gnt_idx_q, gnt_idx_d;
    logic [IW-1:0] last_idx_q, last_idx_d;
    logic [15:0]   wd_cnt_q, wd_cnt_d;
    logic          unmap_err_q, unmap_err_d;

    logic          cur_cyc, cur_stb, cur_we;
    logic [SW-1:0] cur_sel;
    logic [AW-1:0] cur_adr;
    logic [DW-1:0] cur_dat;
    logic [IW-1:0] cand;
    logic [HW-1:0] hit_idx;
    logic          any_hit;
    logic [DW-1:0] hit_dat;
    logic          hit_ack, hit_err, hit_rty;
    logic          req, wd_fire, slv_stb, unmap_pend;
    logic          ack, err, rty;

    // Granted master's request, muxed from gnt_idx regardless of decode.
    always_comb begin
        cur_cyc = 1'b0;
        cur_stb = 1'b0;
        cur_we  = 1'b0;
        cur_sel = '0;
        cur_adr = '0;
        cur_dat = '0;
        for (int i = 0; i < int'(NM); i++) begin
            if (gnt_idx_q == IW'(i)) begin
                cur_cyc = bus.m_cyc_i[i];
                cur_stb = bus.m_stb_i[i];
                cur_we  = bus.m_we_i[i];
                cur_sel = bus.m_sel_i[i*SW +: SW];
                cur_adr = bus.m_adr_i[i*AW +: AW];
                cur_dat = bus.m_dat_i[i*DW +: DW];
            end
        end
    end

    // Round-robin search starts just after the previous winner.
    always_comb begin
        gnt_vld_d  = gnt_vld_q;
        gnt_idx_d  = gnt_idx_q;
        last_idx_d = last_idx_q;
        cand       = '0;
        if (!gnt_vld_q || !cur_cyc) begin
            gnt_vld_d = 1'b0;
            for (int k = int'(NM); k >= 1; k--) begin
                cand = IW'((int'(last_idx_q) + k) % int'(NM));
                if (bus.m_cyc_i[cand]) begin
                    gnt_vld_d = 1'b1;
                    gnt_idx_d = cand;
                end
            end
            if (gnt_vld_d) begin
                last_idx_d = gnt_idx_d;
            end
        end
    end

    // Descending scan so the lowest matching slave wins on overlap.
    always_comb begin
        hit_idx = '0;
        any_hit = 1'b0;
        for (int i = int'(NS) - 1; i >= 0; i--) begin
            if ((cur_adr & SLV_MASK[i*AW +: AW]) == (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW]))
            begin
                hit_idx = HW'(i);
                any_hit = 1'b1;
            end
        end
    end

    always_comb begin
        hit_dat = '0;
        hit_ack = 1'b0;
        hit_err = 1'b0;
        hit_rty = 1'b0;
        for (int i = 0; i < int'(NS); i++) begin
            if (hit_idx == HW'(i)) begin
                hit_dat = bus.s_dat_i[i*DW +: DW];
                hit_ack = bus.s_ack_i[i];
                hit_err = bus.s_err_i[i];
                hit_rty = bus.s_rty_i[i];
            end
        end
    end

    always_comb begin
        req        = gnt_vld_q & cur_cyc & cur_stb;
        wd_fire    = req & (wd_cnt_q == WdLast);
        slv_stb    = req & any_hit & ~wd_fire;
        unmap_pend = unmap_err_q & gnt_vld_q & cur_cyc;
        ack        = hit_ack & slv_stb;
        err        = (hit_err & slv_stb) | unmap_pend | wd_fire;
        rty        = hit_rty & slv_stb;

        bus.s_cyc_o = '0;
        bus.s_stb_o = '0;
        if (any_hit) begin
            bus.s_cyc_o[hit_idx] = gnt_vld_q & cur_cyc;
            bus.s_stb_o[hit_idx] = slv_stb;
        end
        bus.s_we_o  = cur_we;
        bus.s_sel_o = cur_sel;
        bus.s_adr_o = cur_adr;
        bus.s_dat_o = cur_dat;

        bus.m_ack_o = '0;
        bus.m_err_o = '0;
        bus.m_rty_o = '0;
        if (gnt_vld_q) begin
            bus.m_ack_o[gnt_idx_q] = ack;
            bus.m_err_o[gnt_idx_q] = err;
            bus.m_rty_o[gnt_idx_q] = rty;
        end
        bus.m_dat_o = {NM{hit_dat}};

        // Suppressed while pending so a lingering strobe gives a single-cycle pulse.
        unmap_err_d = req & ~any_hit & ~unmap_err_q & ~wd_fire;
        wd_cnt_d    = (req && !(ack || err || rty)) ? wd_cnt_q + 16'd1 : 16'd0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gnt_vld_q   <= 1'b0;
            gnt_idx_q   <= '0;
            last_idx_q  <= IW'(NM - 1);
            wd_cnt_q    <= '0;
            unmap_err_q <= 1'b0;
        end else begin
            gnt_vld_q   <= gnt_vld_d;
            gnt_idx_q   <= gnt_idx_d;
            last_idx_q  <= last_idx_d;
            wd_cnt_q    <= wd_cnt_d;
            unmap_err_q <= unmap_err_d;
        end
    end
endmodule

// File: tb/tb_wb_shared_bus.sv
// Self-checking bench for wb_shared_bus: directed scenarios followed by random single-master
// transfers and random arbitration rounds, checked against a transaction-level model.
module tb_wb_shared_bus;
    localparam int NM = 3;
    localparam int NS = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_shared_bus_if #(.NM(NM), .NS(NS), .AW(AW), .DW(DW)) bus ();

    wb_shared_bus #(.NM(NM), .NS(NS), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int last_win = NM - 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Slaves sit on 256 MB windows at 0x0, 0x1000_0000, 0x2000_0000.
    function automatic int exp_slave(input logic [31:0] adr);
        int n;
        n = int'(adr[31:28]);
        return (n < NS) ? n : -1;
    endfunction

    function automatic logic [NS-1:0] oh_s(input int i);
        logic [NS-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [NM-1:0] oh_m(input int i);
        logic [NM-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic check_idle(input string tag);
        @(negedge clk);
        chk({tag, "_scyc"}, bus.s_cyc_o, '0);
        chk({tag, "_sstb"}, bus.s_stb_o, '0);
        chk({tag, "_term"}, bus.m_ack_o | bus.m_err_o | bus.m_rty_o, '0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        last_win = NM - 1;
    endtask

    // One transfer from master m starting with the bus idle; resp 0/1/2 = ack/err/rty.
    task automatic xfer(input int m, input logic [31:0] adr, input logic we, input int lat,
                        input int resp, input logic [31:0] rd, input logic [31:0] wd,
                        input logic [3:0] sel);
        int es, n, kind, slv, seen, ekind, en;
        logic stray;
        logic [NS-1:0] term_stb;
        es = exp_slave(adr);
        bus.m_cyc_i[m] = 1'b1;
        bus.m_stb_i[m] = 1'b1;
        bus.m_we_i[m] = we;
        bus.m_adr_i[m*AW +: AW] = adr;
        bus.m_dat_i[m*DW +: DW] = wd;
        bus.m_sel_i[m*4 +: 4] = sel;
        n = 0; kind = 0; slv = -1; seen = 0; stray = 1'b0; term_stb = '0;
        while (kind == 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("arb_latency", bus.s_cyc_o, '0);
            if (bus.s_stb_o != '0) begin
                if (seen == 0) begin
                    chk("first_stb_cycle", n, 2);
                    chk("s_cyc_o", bus.s_cyc_o, oh_s(es));
                    chk("s_adr_o", bus.s_adr_o, adr);
                    chk("s_we_o", bus.s_we_o, we);
                    chk("s_dat_o", bus.s_dat_o, wd);
                    chk("s_sel_o", bus.s_sel_o, sel);
                end
                seen++;
                for (int j = NS - 1; j >= 0; j--) if (bus.s_stb_o[j]) slv = j;
                if (seen > lat) begin
                    bus.s_dat_i[slv*DW +: DW] = rd;
                    if (resp == 0) bus.s_ack_i[slv] = 1'b1;
                    else if (resp == 1) bus.s_err_i[slv] = 1'b1;
                    else bus.s_rty_i[slv] = 1'b1;
                end
            end
            #1;
            if (bus.m_ack_o[m]) kind = 1;
            else if (bus.m_err_o[m]) kind = 2;
            else if (bus.m_rty_o[m]) kind = 3;
            if (((bus.m_ack_o | bus.m_err_o | bus.m_rty_o) & ~oh_m(m)) != '0) stray = 1'b1;
            if (kind == 1) chk("m_dat_o", bus.m_dat_o[m*DW +: DW], rd);
            if (kind != 0) term_stb = bus.s_stb_o;
            @(posedge clk);
            #1;
            bus.s_ack_i = '0;
            bus.s_err_i = '0;
            bus.s_rty_i = '0;
        end
        bus.m_cyc_i[m] = 1'b0;
        bus.m_stb_i[m] = 1'b0;
        if (es < 0) begin
            ekind = 2; en = 3;
        end else if (lat < TO - 1) begin
            ekind = resp + 1; en = 2 + lat;
        end else begin
            ekind = 2; en = 1 + TO;
        end
        chk("term_kind", kind, ekind);
        chk("term_cycle", n, en);
        chk("strobed_slave", slv, (es < 0) ? -1 : es);
        chk("term_stb", term_stb, (ekind == 2 && (es < 0 || lat >= TO - 1)) ? '0 : oh_s(es));
        chk("stray_term", stray, 1'b0);
        check_idle("post_xfer");
        last_win = m;
    endtask

    // All masters in mask request together, each does one write to slave 0 then drops cyc.
    task automatic arb(input logic [NM-1:0] mask);
        int order[$];
        logic [NM-1:0] pend;
        int cur, n, last_n, a, w;
        pend = mask;
        cur = last_win;
        while (pend != '0) begin
            for (int k = 1; k <= NM; k++) begin
                if (pend[(cur + k) % NM]) begin
                    cur = (cur + k) % NM;
                    order.push_back(cur);
                    pend[cur] = 1'b0;
                    break;
                end
            end
        end
        for (int i = 0; i < NM; i++) begin
            if (mask[i]) begin
                bus.m_cyc_i[i] = 1'b1;
                bus.m_stb_i[i] = 1'b1;
                bus.m_we_i[i] = 1'b1;
                bus.m_adr_i[i*AW +: AW] = 32'h0000_0100 + 32'(i * 4);
                bus.m_dat_i[i*DW +: DW] = $urandom;
            end
        end
        n = 0;
        last_n = -100;
        while (order.size() > 0 && n < 40) begin
            @(negedge clk);
            n++;
            bus.s_ack_i = bus.s_stb_o;
            #1;
            a = -1;
            if (bus.m_ack_o != '0) begin
                for (int j = NM - 1; j >= 0; j--) if (bus.m_ack_o[j]) a = j;
                w = order.pop_front();
                chk("arb_winner", bus.m_ack_o, oh_m(w));
                if (last_n > 0) chk("arb_gap", n - last_n, 2);
                last_n = n;
            end
            @(posedge clk);
            #1;
            bus.s_ack_i = '0;
            if (a >= 0) begin
                bus.m_cyc_i[a] = 1'b0;
                bus.m_stb_i[a] = 1'b0;
            end
        end
        chk("arb_all_served", order.size(), 0);
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        check_idle("post_arb");
        last_win = cur;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int m, r, lat, resp;
        logic [31:0] adr;
        rst = 1'b1;
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        bus.m_we_i = '0;
        bus.m_sel_i = '0;
        bus.m_adr_i = '0;
        bus.m_dat_i = '0;
        bus.s_dat_i = {$urandom, $urandom, $urandom};
        bus.s_ack_i = '0;
        bus.s_err_i = '0;
        bus.s_rty_i = '0;
        do_reset();
        check_idle("reset");

        // Master 1 reads slave 1 with three wait cycles.
        xfer(1, 32'h1000_0004, 1'b0, 3, 0, 32'hCAFE_F00D, 32'h0, 4'hF);

        // Round-robin from reset, twice.
        do_reset();
        arb(3'b111);
        arb(3'b111);

        // Master 0 locks the bus across four strobes while master 2 waits.
        bus.m_cyc_i[0] = 1'b1;
        bus.m_adr_i[0*AW +: AW] = 32'h0000_0040;
        tick();
        bus.m_cyc_i[2] = 1'b1;
        bus.m_stb_i[2] = 1'b1;
        bus.m_adr_i[2*AW +: AW] = 32'h1000_0000;
        for (int j = 0; j < 4; j++) begin
            bus.m_stb_i[0] = 1'b1;
            @(negedge clk);
            chk("lock_stb", bus.s_stb_o, 3'b001);
            bus.s_ack_i[0] = 1'b1;
            #1;
            chk("lock_ack", bus.m_ack_o, 3'b001);
            tick();
            bus.s_ack_i = '0;
            bus.m_stb_i[0] = 1'b0;
            @(negedge clk);
            chk("lock_hold", bus.s_cyc_o, 3'b001);
            tick();
        end
        bus.m_cyc_i[0] = 1'b0;
        @(negedge clk);
        chk("lock_dead", bus.s_cyc_o, 3'b000);
        tick();
        @(negedge clk);
        chk("lock_handover", bus.s_stb_o, 3'b010);
        bus.s_ack_i[1] = 1'b1;
        #1;
        chk("lock_m2_ack", bus.m_ack_o, 3'b100);
        tick();
        bus.s_ack_i = '0;
        bus.m_cyc_i[2] = 1'b0;
        bus.m_stb_i[2] = 1'b0;
        check_idle("post_lock");
        last_win = 2;

        // Unmapped address, then a slave that never answers.
        xfer(0, 32'h4000_0000, 1'b1, 0, 0, 32'h0, 32'h1234_5678, 4'h3);
        xfer(0, 32'h2000_0000, 1'b1, 1000, 0, 32'h0, 32'hDEAD_BEEF, 4'hF);

        // Reset while master 1 waits on slave 0.
        bus.m_cyc_i[1] = 1'b1;
        bus.m_stb_i[1] = 1'b1;
        bus.m_adr_i[1*AW +: AW] = 32'h0000_0000;
        tick();
        @(negedge clk);
        chk("pre_rst_stb", bus.s_stb_o, 3'b001);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_mid_stb", bus.s_stb_o, '0);
        chk("rst_mid_cyc", bus.s_cyc_o, '0);
        chk("rst_mid_term", bus.m_ack_o | bus.m_err_o | bus.m_rty_o, '0);
        tick();
        rst = 1'b0;
        bus.m_cyc_i[1] = 1'b0;
        bus.m_stb_i[1] = 1'b0;
        last_win = NM - 1;
        arb(3'b011);

        // Random traffic.
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                arb(3'($urandom_range(1, 7)));
            end else begin
                m = $urandom_range(0, NM - 1);
                r = $urandom_range(0, 3);
                adr = {((r == 3) ? 4'h9 : 4'(r)), 28'($urandom) & 28'hFFF_FFFC};
                case ($urandom_range(0, 4))
                    0: lat = 0;
                    1: lat = 1;
                    2: lat = 2;
                    3: lat = 3;
                    default: lat = 12;
                endcase
                resp = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
                xfer(m, adr, 1'($urandom), lat, resp, $urandom, $urandom, 4'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
